// File: rtl/ladybird_axi_ram_if.sv
// AXI4 bus bundle between the core's memory/fetch master and its RAM.
// ID width is parameterised; address and data are fixed at 32 bits.
interface ladybird_axi_interface #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/ladybird_axi_ram.sv
// AXI4 word RAM responder, one burst at a time, alternating AR/AW grants.
// Define LADYBIRD_AXI_RAM_WRAP_EN to support WRAP bursts (else SLVERR).
module ladybird_axi_ram #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic clk,
  input logic nrst,
  ladybird_axi_interface.slave axi
);

`ifdef LADYBIRD_AXI_RAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {IDLE, R_BURST, W_BURST, B_RESP} state_t;

  state_t      state;
  logic        last_rd;
  logic [31:0] addr;
  logic [7:0]  len;
  logic [7:0]  beat;
  logic [1:0]  burst;
  logic        bad;
  logic [1:0]  acc;
  logic [31:0] mem [DEPTH];

  function automatic logic in_win(input logic [31:0] a);
    return {1'b0, a - BASE_ADDR} < SPAN;
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic bad_burst(
    input logic [1:0] b,
    input logic [7:0] l,
    input logic [2:0] s
  );
    logic wrap_ok;
    wrap_ok = WRAP_EN &&
      (l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15);
    return (s != 3'b010) || (b == 2'b11) ||
      (b == 2'b10 && !wrap_ok);
  endfunction

  // Mask is (len+1)*4-1 because legal WRAP lengths are 2^n-1.
  function automatic logic [31:0] next_addr(
    input logic [31:0] a,
    input logic [1:0]  b,
    input logic [7:0]  l
  );
    logic [31:0] m;
    logic [31:0] inc;
    m = {22'd0, l, 2'b11};
    inc = a + 32'd4;
    next_addr = inc;
    unique case (1'b1)
      (b == 2'b00):            next_addr = a;
      (b == 2'b10 && WRAP_EN): next_addr = (a & ~m) | (inc & m);
      default: ;
    endcase
  endfunction

  function automatic logic [33:0] rd_beat(
    input logic [31:0] a,
    input logic        bad_b
  );
    if (!in_win(a)) return {2'b11, 32'd0};
    if (bad_b) return {2'b10, 32'd0};
    return {2'b00, mem[widx(a)]};
  endfunction

  logic        grant_w;
  logic        ar_fire;
  logic        aw_fire;
  logic        r_fire;
  logic        w_fire;
  logic        b_fire;
  logic        ar_bad;
  logic        aw_bad;
  logic [31:0] nxt;
  logic [33:0] ar_beat;
  logic [33:0] r_beat;
  logic        we;
  logic [1:0]  w_resp;
  logic [1:0]  w_worst;
  logic        unused_ok;

  assign grant_w     = axi.awvalid & (~axi.arvalid | last_rd);
  assign axi.awready = (state == IDLE) & grant_w;
  assign axi.arready = (state == IDLE) & axi.arvalid & ~grant_w;
  assign axi.wready  = (state == W_BURST);

  assign ar_fire = axi.arvalid & axi.arready;
  assign aw_fire = axi.awvalid & axi.awready;
  assign r_fire  = axi.rvalid & axi.rready;
  assign w_fire  = axi.wvalid & axi.wready;
  assign b_fire  = axi.bvalid & axi.bready;

  assign ar_bad  = bad_burst(axi.arburst, axi.arlen, axi.arsize);
  assign aw_bad  = bad_burst(axi.awburst, axi.awlen, axi.awsize);
  assign nxt     = next_addr(addr, burst, len);
  assign ar_beat = rd_beat(axi.araddr, ar_bad);
  assign r_beat  = rd_beat(nxt, bad);
  assign we      = w_fire & ~bad & in_win(addr);

  assign unused_ok = ^axi.wid;

  always_comb begin
    w_resp = 2'b00;
    if (!in_win(addr)) begin
      w_resp = 2'b11;
    end else if (bad || (axi.wlast != (beat == len))) begin
      w_resp = 2'b10;
    end
  end

  assign w_worst = (w_resp > acc) ? w_resp : acc;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (axi.wstrb[i]) begin
          mem[widx(addr)][8*i +: 8] <= axi.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      last_rd    <= 1'b0;
      addr       <= '0;
      len        <= '0;
      beat       <= '0;
      burst      <= '0;
      bad        <= 1'b0;
      acc        <= '0;
      axi.rid    <= '0;
      axi.rdata  <= '0;
      axi.rresp  <= '0;
      axi.rlast  <= 1'b0;
      axi.rvalid <= 1'b0;
      axi.bid    <= '0;
      axi.bresp  <= '0;
      axi.bvalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ar_fire) begin
            addr       <= axi.araddr;
            len        <= axi.arlen;
            burst      <= axi.arburst;
            bad        <= ar_bad;
            beat       <= '0;
            last_rd    <= 1'b1;
            axi.rid    <= axi.arid;
            axi.rresp  <= ar_beat[33:32];
            axi.rdata  <= ar_beat[31:0];
            axi.rlast  <= (axi.arlen == 8'd0);
            axi.rvalid <= 1'b1;
            state      <= R_BURST;
          end else if (aw_fire) begin
            addr    <= axi.awaddr;
            len     <= axi.awlen;
            burst   <= axi.awburst;
            bad     <= aw_bad;
            beat    <= '0;
            acc     <= '0;
            last_rd <= 1'b0;
            axi.bid <= axi.awid;
            state   <= W_BURST;
          end
        end
        R_BURST: begin
          if (r_fire) begin
            if (axi.rlast) begin
              axi.rvalid <= 1'b0;
              axi.rlast  <= 1'b0;
              state      <= IDLE;
            end else begin
              addr      <= nxt;
              axi.rresp <= r_beat[33:32];
              axi.rdata <= r_beat[31:0];
              axi.rlast <= ((beat + 8'd1) == len);
              beat      <= beat + 8'd1;
            end
          end
        end
        W_BURST: begin
          if (w_fire) begin
            addr <= nxt;
            beat <= beat + 8'd1;
            acc  <= w_worst;
            if (beat == len) begin
              axi.bresp  <= w_worst;
              axi.bvalid <= 1'b1;
              state      <= B_RESP;
            end
          end
        end
        B_RESP: begin
          if (b_fire) begin
            axi.bvalid <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ladybird_axi_ram.sv
// Scoreboard bench for ladybird_axi_ram: directed cases then random bursts
// checked against an array model of the RAM and the AXI response rules.
module tb_ladybird_axi_ram;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef LADYBIRD_AXI_RAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  ladybird_axi_interface axi ();

  ladybird_axi_ram #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .nrst (nrst),
    .axi  (axi)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    bit          known;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  int          checks = 0;
  int          errors = 0;
  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] mdl [int];
  byte         grants[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=no-handshake required=handshake", name);
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return longint'(a) >= longint'(BASE) &&
           longint'(a) < longint'(BASE) + 4 * DEPTH;
  endfunction

  function automatic bit is_bad(input logic [1:0] b, input logic [7:0] l,
                                input logic [2:0] s);
    if (s != 3'd2) return 1'b1;
    if (b == 2'b10)
      return !(WRAP_EN && (l == 1 || l == 3 || l == 7 || l == 15));
    return 1'b0;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a,
    input logic [1:0] b, input logic [7:0] l, input int i);
    int unsigned sz;
    logic [31:0] lo;
    if (b == 2'b00) return a;
    if (b == 2'b10 && WRAP_EN) begin
      sz = (int'(l) + 1) * 4;
      lo = a - (a % sz);
      return lo + ((a - lo + 32'(4 * i)) % sz);
    end
    return a + 32'(4 * i);
  endfunction

  function automatic logic rr_bit(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_read(input logic [3:0] id, input logic [31:0] a,
    input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size,
    input int mode);
    bit    b;
    rexp_t e;
    logic [31:0] ba;
    int    idx, n, k;
    bit    fin;
    b = is_bad(burst, len, size);
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, burst, len, i);
      e.id = id;
      e.last = (i == int'(len));
      e.known = 1'b1;
      e.data = '0;
      if (!in_win(ba)) e.resp = 2'b11;
      else if (b) e.resp = 2'b10;
      else begin
        e.resp = 2'b00;
        idx = int'((ba - BASE) >> 2);
        e.known = mdl.exists(idx);
        if (e.known) e.data = mdl[idx];
      end
      rq.push_back(e);
    end
    axi.arid = id;
    axi.araddr = a;
    axi.arlen = len;
    axi.arburst = burst;
    axi.arsize = size;
    axi.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.arready) begin
      n++;
      if (n > 200) begin
        timeout("ar_wait");
        axi.arvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    axi.arvalid = 1'b0;
    k = 0;
    axi.rready = rr_bit(mode, k);
    @(negedge clk);
    check("r_latency", axi.rvalid, 1);
    n = 0;
    forever begin
      fin = axi.rvalid && axi.rready && axi.rlast;
      @(posedge clk);
      #1;
      if (fin) break;
      n++;
      if (n > 400) begin
        timeout("r_wait");
        break;
      end
      k++;
      axi.rready = rr_bit(mode, k);
      @(negedge clk);
    end
    axi.rready = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a,
    input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size,
    input logic [31:0] d [16], input logic [3:0] s [16], input int bb);
    bit    b;
    bexp_t e;
    logic [31:0] ba, old;
    logic [1:0] r, worst;
    int    idx, n;
    bit    ok;
    b = is_bad(burst, len, size);
    worst = 2'b00;
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, burst, len, i);
      r = 2'b00;
      if (!in_win(ba)) r = 2'b11;
      else if (b) r = 2'b10;
      else begin
        idx = int'((ba - BASE) >> 2);
        ok = 1'b1;
        old = '0;
        if (mdl.exists(idx)) old = mdl[idx];
        else if (s[i] != 4'hF) ok = 1'b0;
        if (ok) begin
          for (int j = 0; j < 4; j++)
            if (s[i][j]) old[8*j +: 8] = d[i][8*j +: 8];
          mdl[idx] = old;
        end
      end
      if (i == bb && r < 2'b10) r = 2'b10;
      if (r > worst) worst = r;
    end
    e.id = id;
    e.resp = worst;
    bq.push_back(e);
    axi.awid = id;
    axi.awaddr = a;
    axi.awlen = len;
    axi.awburst = burst;
    axi.awsize = size;
    axi.awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.awready) begin
      n++;
      if (n > 200) begin
        timeout("aw_wait");
        axi.awvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    axi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        axi.wvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      axi.wdata = d[i];
      axi.wstrb = s[i];
      axi.wid = id;
      axi.wlast = (i == int'(len)) ^ (i == bb);
      axi.wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!axi.wready) begin
        n++;
        if (n > 200) begin
          timeout("w_wait");
          axi.wvalid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      @(posedge clk);
      #1;
    end
    axi.wvalid = 1'b0;
    axi.wlast = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    axi.bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.bvalid) begin
      n++;
      if (n > 200) begin
        timeout("b_wait");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    axi.bready = 1'b0;
  endtask

  // Monitor: pops expectations on every R/B handshake, checks hold rules.
  logic        prev_hold = 1'b0;
  logic [34:0] prev_r;
  always @(negedge clk) begin
    rexp_t re;
    bexp_t be;
    if (!nrst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("r_hold_valid", axi.rvalid, 1);
        check("r_hold_beat", {axi.rdata, axi.rresp, axi.rlast}, prev_r);
      end
      prev_hold = axi.rvalid && !axi.rready;
      prev_r = {axi.rdata, axi.rresp, axi.rlast};
      if (axi.rvalid && axi.rready) begin
        if (rq.size() == 0) begin
          timeout("r_unexpected");
        end else begin
          re = rq.pop_front();
          check("r_id", axi.rid, re.id);
          check("r_resp", axi.rresp, re.resp);
          check("r_last", axi.rlast, re.last);
          if (re.known) check("r_data", axi.rdata, re.data);
        end
      end
      if (axi.bvalid && axi.bready) begin
        if (bq.size() == 0) begin
          timeout("b_unexpected");
        end else begin
          be = bq.pop_front();
          check("b_id", axi.bid, be.id);
          check("b_resp", axi.bresp, be.resp);
        end
      end
      if (axi.arvalid && axi.arready) grants.push_back(8'h52);
      if (axi.awvalid && axi.awready) grants.push_back(8'h57);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    int          bb;
    byte         exp_g [3];
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0;
    axi.awburst = '0; axi.awvalid = 0;
    axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 0;
    axi.wvalid = 0; axi.bready = 0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
    axi.arburst = '0; axi.arvalid = 0; axi.rready = 0;
    for (int i = 0; i < 16; i++) begin
      wd[i] = '0;
      ws[i] = 4'hF;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", axi.arready, 0);
    check("rst_awready", axi.awready, 0);
    check("rst_wready", axi.wready, 0);
    check("rst_bvalid", axi.bvalid, 0);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_rlast", axi.rlast, 0);
    check("rst_rdata", axi.rdata, 0);
    check("rst_bresp", axi.bresp, 0);
    check("rst_rresp", axi.rresp, 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;

    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    do_write(4'd2, 32'h10, 8'd0, 2'b01, 3'd2, wd, ws, -1);
    do_read(4'd1, 32'h10, 8'd0, 2'b01, 3'd2, 0);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write(4'd6, 32'h10, 8'd0, 2'b01, 3'd2, wd, ws, -1);
    do_read(4'd7, 32'h10, 8'd0, 2'b01, 3'd2, 0);

    for (int i = 0; i < 16; i++) begin
      wd[i] = 32'(i);
      ws[i] = 4'hF;
    end
    do_write(4'd8, 32'h100, 8'd3, 2'b01, 3'd2, wd, ws, -1);
    do_read(4'd9, 32'h100, 8'd3, 2'b01, 3'd2, 1);
    do_read(4'd10, 32'h104, 8'd2, 2'b00, 3'd2, 1);

    // Reset keeps memory but must restore read-first arbitration.
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    grants.delete();
    wd[0] = 32'h5A5A_0180;
    fork
      begin
        do_read(4'd3, 32'h100, 8'd1, 2'b01, 3'd2, 0);
        do_read(4'd4, 32'h108, 8'd0, 2'b01, 3'd2, 0);
      end
      do_write(4'd5, 32'h180, 8'd0, 2'b01, 3'd2, wd, ws, -1);
    join
    exp_g[0] = 8'h52; exp_g[1] = 8'h57; exp_g[2] = 8'h52;
    for (int i = 0; i < 3; i++)
      check("arb_grant", (i < grants.size()) ? grants[i] : 8'h00, exp_g[i]);

    wd[0] = 32'hCAFE_F00D;
    do_write(4'd1, 32'h0, 8'd0, 2'b01, 3'd2, wd, ws, -1);
    wd[0] = 32'hDEAD_BEEF;
    do_write(4'd2, BASE + 32'(4 * DEPTH), 8'd0, 2'b01, 3'd2, wd, ws, -1);
    do_read(4'd3, 32'h0, 8'd0, 2'b01, 3'd2, 0);
    do_read(4'd4, BASE + 32'(4 * DEPTH), 8'd0, 2'b01, 3'd2, 0);
    wd[0] = 32'h1234_0020; wd[1] = 32'h1234_0024;
    do_write(4'd5, 32'h20, 8'd1, 2'b01, 3'd2, wd, ws, 0);
    do_read(4'd6, 32'h20, 8'd1, 2'b01, 3'd2, 2);
    wd[0] = 32'h0BAD_0EDE; wd[1] = 32'h0BAD_0EDF;
    do_write(4'd7, BASE + 32'(4 * DEPTH - 4), 8'd1, 2'b01, 3'd2, wd, ws, -1);
    do_read(4'd8, BASE + 32'(4 * DEPTH - 4), 8'd1, 2'b01, 3'd2, 0);
    wd[0] = 32'hFFFF_FFFF;
    do_write(4'd9, 32'h10, 8'd0, 2'b01, 3'd1, wd, ws, -1);
    do_read(4'd10, 32'h10, 8'd0, 2'b01, 3'd1, 0);
    do_read(4'd11, 32'h10, 8'd0, 2'b01, 3'd2, 0);
    do_read(4'd12, 32'h108, 8'd3, 2'b10, 3'd2, 0);

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'hF;
      end
      do_write(4'(k), 32'h200 + 32'(64 * k), 8'd15, 2'b01, 3'd2, wd, ws, -1);
    end
    for (int t = 0; t < 120; t++) begin
      a = 32'h200 + 32'(4 * $urandom_range(0, 63));
      burst = 2'($urandom_range(0, 2));
      if (burst == 2'b10) len = 8'((2 << $urandom_range(0, 2)) - 1);
      else len = 8'($urandom_range(0, 7));
      size = ($urandom_range(0, 11) == 0) ? 3'd1 : 3'd2;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wd[i] = $urandom;
          ws[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        end
        bb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
        do_write(4'($urandom), a, len, burst, size, wd, ws, bb);
      end else begin
        do_read(4'($urandom), a, len, burst, size,
                int'($urandom_range(0, 2)));
      end
    end

    repeat (4) @(posedge clk);
    check("rq_empty", rq.size(), 0);
    check("bq_empty", bq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
